// File: rtl/rot_addr_sequencer.sv
// rot_addr_sequencer
//   Address/sequencing controller for the rotation engine DMA path (I_HCLK domain).
//   After I_START it walks the H x W source image in raster order. For every pixel
//   it issues one source read request, then one destination write request whose
//   address already has the rotation remap applied.
//
//   State | meaning
//   IDLE  | waiting for I_START; config is latched on the start cycle
//   SETUP | derive quarter turns k, rotated dims, first addresses and steps
//   RD    | O_RD_VALID held with a stable O_RD_ADDR until I_RD_READY
//   WR    | O_WR_VALID held with a stable O_WR_ADDR until I_WR_READY
//   DONE  | one-cycle O_DONE pulse, then back to IDLE
//
// Ports
//   I_HCLK, I_HRESET (sync, active high), I_START, I_ABORT
//   I_SRC_BASE, I_DST_BASE, I_HEIGHT, I_WIDTH, I_MODE, I_DIRECTION : frame config
//   O_RD_VALID/O_RD_ADDR/I_RD_READY : source read request channel
//   O_WR_VALID/O_WR_ADDR/I_WR_READY : destination write request channel
//   O_BUSY, O_DONE, O_NEW_HEIGHT, O_NEW_WIDTH : status
//   O_STALL_CNT : only when ROT_STALL_CNT_EN is defined; cycles spent in RD/WR
//                 with ready low (clears on start, saturates, holds after done)
module rot_addr_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16,
  parameter int BPP    = 4
) (
  input  logic              I_HCLK,
  input  logic              I_HRESET,
  input  logic              I_START,
  input  logic              I_ABORT,
  input  logic [ADDR_W-1:0] I_SRC_BASE,
  input  logic [ADDR_W-1:0] I_DST_BASE,
  input  logic [DIM_W-1:0]  I_HEIGHT,
  input  logic [DIM_W-1:0]  I_WIDTH,
  input  logic [1:0]        I_MODE,
  input  logic              I_DIRECTION,
  output logic              O_RD_VALID,
  output logic [ADDR_W-1:0] O_RD_ADDR,
  input  logic              I_RD_READY,
  output logic              O_WR_VALID,
  output logic [ADDR_W-1:0] O_WR_ADDR,
  input  logic              I_WR_READY,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic [DIM_W-1:0]  O_NEW_HEIGHT,
  output logic [DIM_W-1:0]  O_NEW_WIDTH
`ifdef ROT_STALL_CNT_EN
  ,
  output logic [31:0]       O_STALL_CNT
`endif
);

  localparam logic [ADDR_W-1:0] BPP_A = ADDR_W'(BPP);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [DIM_W-1:0]  h_q, w_q, row_q, col_q;
  logic [1:0]        mode_q;
  logic              dir_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q, col_step_q, row_step_q;
  logic              rd_valid_q, wr_valid_q, busy_q, done_q;
  logic [DIM_W-1:0]  new_h_q, new_w_q;

  logic [1:0]        k_d;
  logic [ADDR_W-1:0] h_ext, w_ext, wm1h_d, wr_off_d, col_step_d, row_step_d;
  logic [DIM_W-1:0]  new_h_d, new_w_d;
  logic              last_col, last_row;

  // The destination offset is walked incrementally: a fixed step while moving
  // along a source row, and a different fixed step when the row wraps.
  always_comb begin
    k_d     = dir_q ? mode_q : (2'd0 - mode_q);
    h_ext   = ADDR_W'(h_q);
    w_ext   = ADDR_W'(w_q);
    wm1h_d  = (w_ext - ONE_A) * h_ext;
    new_h_d = k_d[0] ? w_q : h_q;
    new_w_d = k_d[0] ? h_q : w_q;
    case (k_d)
      2'd0: begin
        wr_off_d   = '0;
        col_step_d = BPP_A;
        row_step_d = BPP_A;
      end
      2'd1: begin
        wr_off_d   = (h_ext - ONE_A) * BPP_A;
        col_step_d = h_ext * BPP_A;
        row_step_d = -((wm1h_d + ONE_A) * BPP_A);
      end
      2'd2: begin
        wr_off_d   = (h_ext * w_ext - ONE_A) * BPP_A;
        col_step_d = -BPP_A;
        row_step_d = -BPP_A;
      end
      default: begin
        wr_off_d   = wm1h_d * BPP_A;
        col_step_d = -(h_ext * BPP_A);
        row_step_d = (wm1h_d + ONE_A) * BPP_A;
      end
    endcase
    last_col = (col_q == w_q - ONE_D);
    last_row = (row_q == h_q - ONE_D);
  end

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      h_q        <= '0;
      w_q        <= '0;
      mode_q     <= '0;
      dir_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      col_step_q <= '0;
      row_step_q <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      new_h_q    <= '0;
      new_w_q    <= '0;
    end else if (state_q == S_IDLE) begin
      // Abort is meaningless here, so a coincident start wins.
      done_q <= 1'b0;
      if (I_START) begin
        src_q   <= I_SRC_BASE;
        dst_q   <= I_DST_BASE;
        h_q     <= I_HEIGHT;
        w_q     <= I_WIDTH;
        mode_q  <= I_MODE;
        dir_q   <= I_DIRECTION;
        row_q   <= '0;
        col_q   <= '0;
        busy_q  <= 1'b1;
        state_q <= S_SETUP;
      end
    end else if (I_ABORT && state_q != S_DONE) begin
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b1;
      state_q    <= S_DONE;
    end else begin
      case (state_q)
        S_SETUP: begin
          new_h_q    <= new_h_d;
          new_w_q    <= new_w_d;
          rd_addr_q  <= src_q;
          wr_addr_q  <= dst_q + wr_off_d;
          col_step_q <= col_step_d;
          row_step_q <= row_step_d;
          if (h_q == '0 || w_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            rd_valid_q <= 1'b1;
            state_q    <= S_RD;
          end
        end
        S_RD: begin
          if (I_RD_READY) begin
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b1;
            state_q    <= S_WR;
          end
        end
        S_WR: begin
          if (I_WR_READY) begin
            wr_valid_q <= 1'b0;
            if (last_col && last_row) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              if (last_col) begin
                col_q     <= '0;
                row_q     <= row_q + ONE_D;
                wr_addr_q <= wr_addr_q + row_step_q;
              end else begin
                col_q     <= col_q + ONE_D;
                wr_addr_q <= wr_addr_q + col_step_q;
              end
              rd_addr_q  <= rd_addr_q + BPP_A;
              rd_valid_q <= 1'b1;
              state_q    <= S_RD;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_RD_VALID   = rd_valid_q;
  assign O_RD_ADDR    = rd_addr_q;
  assign O_WR_VALID   = wr_valid_q;
  assign O_WR_ADDR    = wr_addr_q;
  assign O_BUSY       = busy_q;
  assign O_DONE       = done_q;
  assign O_NEW_HEIGHT = new_h_q;
  assign O_NEW_WIDTH  = new_w_q;

`ifdef ROT_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      stall_cnt_q <= '0;
    end else if (state_q == S_IDLE && I_START) begin
      stall_cnt_q <= '0;
    end else if (((state_q == S_RD && !I_RD_READY) || (state_q == S_WR && !I_WR_READY))
                 && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign O_STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: doc/rot_addr_sequencer.md
Name: rot_addr_sequencer

Overview:
- Address and sequencing controller for the rotation engine's AHB DMA path.
- After a start command, walks every source pixel of an H x W image in raster order. For each pixel it issues one source read address, then one destination write address, with the rotation remapping already applied.
- Sits between the APB register file and the AHB DMA master, in the I_HCLK domain. Pulses a done strobe that feeds O_INTR_DONE logic.

Parameters:
- ADDR_W, 32, address width of source, destination and DMA addresses.
- DIM_W, 16, width of height/width fields; max image dimension is 2^DIM_W-1.
- BPP, 4, bytes per pixel; address stride between horizontally adjacent pixels.

Ports:
- I_HCLK  in  1  sole clock.
- I_HRESET  in  1  synchronous active-high reset.
- I_START  in  1  single-cycle start pulse; registers below are sampled on this cycle.
- I_ABORT  in  1  soft reset from the register block.
- I_SRC_BASE  in  ADDR_W  source image base address.
- I_DST_BASE  in  ADDR_W  destination image base address.
- I_HEIGHT  in  DIM_W  source rows H.
- I_WIDTH  in  DIM_W  source columns W.
- I_MODE  in  2  0=0deg, 1=90, 2=180, 3=270.
- I_DIRECTION  in  1  0=ccw, 1=cw.
- O_RD_VALID  out  1  source read request valid.
- O_RD_ADDR  out  ADDR_W  source read address.
- I_RD_READY  in  1  DMA accepted the read; data is captured by the DMA.
- O_WR_VALID  out  1  destination write request valid.
- O_WR_ADDR  out  ADDR_W  destination write address.
- I_WR_READY  in  1  DMA accepted the write.
- O_BUSY  out  1  high from the cycle after start until done.
- O_DONE  out  1  one-cycle pulse when the frame completes or is aborted.
- O_NEW_HEIGHT  out  DIM_W  rotated height, valid while busy and after done.
- O_NEW_WIDTH  out  DIM_W  rotated width.

Behaviour:
- Reset: synchronous active-high, applied on I_HCLK rising edge. All outputs are 0; state is IDLE; row/col counters are 0; latched configuration is 0.
- Effective clockwise quarter turns: k = I_DIRECTION ? I_MODE : (4 - I_MODE) mod 4.
- Output dimensions: k even gives new dims H x W; k odd gives new dims W x H (O_NEW_HEIGHT=W, O_NEW_WIDTH=H).
- Source pixel (r,c), 0<=r<H, 0<=c<W: rd addr = SRC + (r*W + c)*BPP.
- Destination coordinates (R,C) by k:
  - k=0: R=r, C=c.
  - k=1: R=c, C=H-1-r.
  - k=2: R=H-1-r, C=W-1-c.
  - k=3: R=W-1-c, C=r.
- Destination address: wr addr = DST + (R*O_NEW_WIDTH + C)*BPP, computed modulo 2^ADDR_W (wrap, no error).
- Multiplies may be replaced by incremental adders; results must be identical.
- States: IDLE, SETUP, RD, WR, DONE.
  - IDLE: I_START latches all config and moves to SETUP. O_BUSY rises the next cycle.
  - SETUP: one cycle; computes k, new dims and first addresses. If H==0 or W==0, goes to DONE with no requests; otherwise goes to RD.
  - RD: O_RD_VALID=1 with a stable O_RD_ADDR. When I_RD_READY is sampled high, goes to WR.
  - WR: O_WR_VALID=1 with a stable O_WR_ADDR. When I_WR_READY is sampled high, advances c. When c wraps at W-1, c=0 and r increments. After pixel (H-1,W-1) goes to DONE; otherwise goes to RD.
  - DONE: O_DONE=1 for one cycle, O_BUSY=0, then IDLE.
- Handshake rules:
  - RD and WR are never valid in the same cycle.
  - Valid, once asserted, holds with a stable address until ready.
  - Ready while valid is low is ignored.
- Per-pixel throughput: minimum 2 cycles (1 RD + 1 WR) with ready held high.
- I_START while busy is ignored. Config inputs may change while busy without effect.
- I_ABORT has priority over all transitions except reset. In any non-IDLE state it drops valids the same cycle it is registered, enters DONE, and O_DONE pulses. In IDLE it has no effect.
- I_ABORT and I_START in the same cycle in IDLE: start is taken.

Optional Feature:
- Macro: ROT_STALL_CNT_EN.
- When defined: adds output O_STALL_CNT [31:0], counting cycles in RD or WR with ready low. It clears on I_START accepted and on reset, saturates at 0xFFFFFFFF, and holds after done.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- SRC=0x1000, DST=0x2000, H=1, W=1, mode 0, cw, ready always high -> one RD at 0x1000, one WR at 0x2000, O_DONE 1 cycle after the WR handshake, new dims 1x1.
- H=2, W=3, mode 1, cw (k=1) -> new dims 3x2. Write sequence 0x2004, 0x200C, 0x2014, 0x2000, 0x2008, 0x2010. Reads at 0x1000..0x1014 step 4.
- Same image, mode 3, ccw (k=1) -> identical write sequence to the previous case. Mode 1, ccw (k=3) -> first write 0x2010, last write 0x2004.
- H=2, W=2, mode 2, cw, I_WR_READY low for 5 cycles on the first pixel -> O_WR_ADDR held at 0x200C throughout the stall. With ROT_STALL_CNT_EN, O_STALL_CNT=5 at done.
- H=4, W=4, abort asserted during the 3rd RD -> valids low next cycle, O_DONE pulses once, O_BUSY 0. A new start then runs from pixel (0,0).
- H=0, W=5, start -> no RD/WR issued, O_DONE pulses 2 cycles after start. A start during busy in other cases is ignored (request count unchanged).
